tone_gen: RTL

Audio tone generator for the button sequence detector. It consumes the detector's `tone_EN362` / `tone_EN110` enables and drives the Arty Z7-10 mono audio output with a glitch-free square wave: 362 Hz for a correct sequence, 110 Hz for an incorrect one. It also drives the amplifier shutdown pin. It sits between the detector and the `aud_pwm` / `aud_sd` board pins.

---
 rtl/tone_gen.sv | 128 ++++++++++++
 1 files changed

// File: rtl/tone_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tone_gen
//  Function : Square-wave tone generator for the sequence detector. Plays a
//             high tone (362 Hz) or low tone (110 Hz) as whole periods only,
//             drives the amplifier enable and flags each completed period.
//  Revision : 1.0  initial release
// ============================================================================
module tone_gen #(
   parameter int HALF_HI = 172652,
   parameter int HALF_LO = 568182,
   parameter int CNT_W   = 20
) (
   input  logic clk,
   input  logic clr,
   input  logic tone_EN362,
   input  logic tone_EN110,
   output logic aud_pwm,
   output logic aud_sd,
   output logic tone_sel,
   output logic period_tick
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   // Terminal counts: the counter runs 0 .. half-1 in each half-period
   localparam logic [CNT_W-1:0] c_hi_last = CNT_W'(HALF_HI - 1);
   localparam logic [CNT_W-1:0] c_lo_last = CNT_W'(HALF_LO - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             pwm_q,   pwm_d;
   logic             sd_q,    sd_d;
   logic             sel_q,   sel_d;
   logic             tick_q,  tick_d;

   logic             w_any_en;
   logic             w_half_done;

   assign w_any_en    = tone_EN362 | tone_EN110;
   // Half length follows the tone latched at the start of the current period
   assign w_half_done = (cnt_q == (sel_q ? c_hi_last : c_lo_last));

   // Next-state logic: enables are only looked at in IDLE and on the last LOW cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pwm_d   = pwm_q;
      sd_d    = sd_q;
      sel_d   = sel_q;
      tick_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            pwm_d = 1'b0;
            sd_d  = 1'b0;
            if (w_any_en) begin
               sel_d   = tone_EN362;
               state_d = HIGH;
               pwm_d   = 1'b1;
               sd_d    = 1'b1;
            end
         end
         HIGH: begin
            if (w_half_done) begin
               cnt_d   = '0;
               state_d = LOW;
               pwm_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LOW: begin
            if (w_half_done) begin
               cnt_d  = '0;
               tick_d = 1'b1;
               if (w_any_en) begin
                  // Back-to-back period; tone may switch only here
                  sel_d   = tone_EN362;
                  state_d = HIGH;
                  pwm_d   = 1'b1;
               end else begin
                  state_d = IDLE;
                  sd_d    = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            pwm_d   = 1'b0;
            sd_d    = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous clear
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pwm_q   <= 1'b0;
         sd_q    <= 1'b0;
         sel_q   <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pwm_q   <= pwm_d;
         sd_q    <= sd_d;
         sel_q   <= sel_d;
         tick_q  <= tick_d;
      end
   end

   assign aud_pwm     = pwm_q;
   assign aud_sd      = sd_q;
   assign tone_sel    = sel_q;
   assign period_tick = tick_q;

endmodule
`default_nettype wire
